unified_cache_request_crossbar: RTL and testbench
=================================================

// Module: unified_cache_request_crossbar
// PURPOSE
//  Routes requests from NUM_INPUT_PORT input queues to NUM_BANK cache banks. Replaces per-bank
//  valid masking plus the OR-merged ack with a true crossbar that has these features:
//  - one registered slot per bank;
//  - critical-first round-robin arbitration with anti-starvation aging;
//  - source port ID stamped into each packet.
//  Sits between the input fifo_queues and the unified_cache_bank instances.
// PARAMETERS
//  NUM_INPUT_PORT  2                                      request sources (>=1)
//  NUM_BANK        4                                      banks, power of 2 (>=1)
//  PACKET_WIDTH    `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS    packet width
//  ADDR_WIDTH      `CPU_DATA_LEN_IN_BITS                  address field, packet bits [ADDR_WIDTH-1:0]
//  BANK_SEL_LO     `UNIFIED_CACHE_INDEX_POS_LO            LSB of the bank-select address bits
//  PORT_NUM_LO     `UNIFIED_CACHE_PACKET_PORT_NUM_LO      LSB of the port-ID field in the packet
//  PORT_ID_WIDTH   $clog2(NUM_INPUT_PORT)+1               port-ID field width
//  STARVE_LIMIT    15                                     wait cycles before a port is promoted to critical
// PORTS
//  clk_in                    in   1                  clock, rising edge
//  reset_in                  in   1                  asynchronous, active-low reset
//  request_flatted_in        in   NUM_INPUT_PORT*PW  per-port packet, port p at [p*PW +: PW]
//  request_valid_flatted_in  in   NUM_INPUT_PORT     per-port request valid
//  request_critical_flatted_in in NUM_INPUT_PORT     per-port urgency (input queue full)
//  issue_ack_out             out  NUM_INPUT_PORT     1-cycle pulse: packet p captured this cycle
//  bank_request_flatted_out  out  NUM_BANK*PW        per-bank registered packet
//  bank_request_valid_flatted_out out NUM_BANK       per-bank slot valid
//  bank_issue_ack_in         in   NUM_BANK           bank consumed its slot this cycle
// BEHAVIOUR
//  - Reset (reset_in==0, async): all slots invalid; packet outputs 0; issue_ack_out 0;
//    RR pointers 0; age counters 0. Reset asserted mid-transfer discards in-flight slots silently.
//  - Target bank: bank(p) = pkt[BANK_SEL_LO +: log2(NUM_BANK)]. NUM_BANK==1 -> always bank 0.
//  - Slot b accepts a packet when it is empty, or when it is valid and bank_issue_ack_in[b]==1
//    (same-cycle drain and refill gives full throughput).
//  - bank_issue_ack_in[b] while slot b is empty is ignored.
//  - Arbitration per bank, combinational over the ports with valid and bank(p)==b:
//    1. Effective-critical set = critical_in[p] | (age[p]==STARVE_LIMIT).
//    2. If that set is non-empty, arbitrate only within it; otherwise arbitrate over all
//       requesters.
//    3. Round-robin: search starts at rr_ptr[b]; on a grant rr_ptr[b] <= winner+1 (mod
//       NUM_INPUT_PORT). The pointer is unchanged when there is no grant.
//  - On grant (winner w, bank b):
//    - slot <= packet with [PORT_NUM_LO +: PORT_ID_WIDTH] overwritten by w;
//    - issue_ack_out[w]=1 in the same cycle (combinational from the grant; the queue pops on
//      this edge);
//    - the output is valid from the next cycle, so latency is 1 cycle.
//  - A port targets exactly one bank, so at most one ack per port per cycle; different ports
//    win different banks in the same cycle.
//  - age[p] increments each cycle p is valid and not acked, saturating at STARVE_LIMIT; it
//    clears on ack or when valid drops.
//  - Slot contents and valid hold steady while valid && !bank_issue_ack_in (no glitching, no
//    reorder).
//  - Per-port order is preserved: a port is acked at most once per packet and packets are never
//    duplicated or dropped.
// STRUCTURE
//  - The packet field macros (VALID_POS, PORT_NUM_LO, INDEX_POS_LO) remain in parameters.h.
//  - Add `UNIFIED_CACHE_STARVE_LIMIT to parameters.h.
//  - Sub-module unified_cache_rr_arbiter: NUM_REQUEST-wide, two-class (critical/normal)
//    round-robin, with outputs grant one-hot, grant_valid and pointer register. Instantiated
//    once per bank in a generate loop.
//  - Age counters and slot registers live in the top module.
// TESTING
//  - Reset: drive valid=all-1 during reset_in=0 -> all outputs 0, no ack. Release -> acks
//    start after the first edge.
//  - Bank routing, 2 ports x 4 banks: port0 addr bank field=2, port1 bank field=1 ->
//    ack=2'b11 in the same cycle; next cycle valid_out=4'b0110 with port IDs 0 and 1 stamped.
//  - Contention: both ports target bank 3 continuously with bank_ack=1 -> grants alternate
//    0,1,0,1; each port gets 50% over 20 cycles.
//  - Critical: port1 critical=1 and port0 normal, both to bank 0 -> port1 wins every cycle
//    while critical. Port0 age hits 15 -> port0 is granted on the next arbitration (tied
//    critical, resolved by RR).
//  - Backpressure: bank_ack[0]=0 for 10 cycles with a valid slot -> slot data stable, no acks
//    to bank-0 requesters. bank_ack=1 -> drain and refill in the same cycle, no bubble.
//  - Mid-op reset: reset_in pulsed low with 3 slots full -> valid_out=0 immediately (async),
//    RR pointers back to 0; the scoreboard drops in-flight packets.

Source files
------------

// File: rtl/unified_cache_request_crossbar_pkg.sv
// Shared constants for the unified-cache request crossbar: packet field positions,
// the starvation limit, and a width helper for index/pointer registers.
package unified_cache_request_crossbar_pkg;

    localparam int UC_PACKET_WIDTH = 40;
    localparam int UC_ADDR_WIDTH   = 32;
    localparam int UC_INDEX_POS_LO = 4;
    localparam int UC_PORT_NUM_LO  = 34;
    localparam int UC_STARVE_LIMIT = 15;

    // Width of an index over n items; never zero so a single item still gets a 1-bit register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unified_cache_rr_arbiter.sv
// Two-class round-robin arbiter: critical requesters win over normal ones, and within the
// chosen class the search starts at the pointer, which moves to winner+1 on every grant.
module unified_cache_rr_arbiter
    import unified_cache_request_crossbar_pkg::*;
#(
    parameter int NUM_REQUEST = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic [NUM_REQUEST-1:0]               request,
    input  logic [NUM_REQUEST-1:0]               critical,
    output logic [NUM_REQUEST-1:0]               grant,
    output logic                                 grant_valid,
    output logic [idx_width(NUM_REQUEST)-1:0]    pointer
);

    localparam int PTR_W = idx_width(NUM_REQUEST);

    logic [PTR_W-1:0]       ptr_q;
    logic [PTR_W-1:0]       winner;
    logic [PTR_W-1:0]       idx;
    logic [NUM_REQUEST-1:0] pool;

    always_comb begin
        pool        = ((request & critical) != '0) ? (request & critical) : request;
        grant       = '0;
        grant_valid = 1'b0;
        winner      = ptr_q;
        idx         = ptr_q;
        for (int i = 0; i < NUM_REQUEST; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % NUM_REQUEST);
            if (enable && !grant_valid && pool[idx]) begin
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
                winner      = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (grant_valid) begin
            ptr_q <= PTR_W'((int'(winner) + 1) % NUM_REQUEST);
        end
    end

    assign pointer = ptr_q;

endmodule

// File: rtl/unified_cache_request_crossbar.sv
// Crossbar from the input request queues to the cache banks: one registered slot per bank,
// critical-first round-robin per bank with starvation aging, source port ID stamped in.
module unified_cache_request_crossbar
    import unified_cache_request_crossbar_pkg::*;
#(
    parameter int NUM_INPUT_PORT = 2,
    parameter int NUM_BANK       = 4,
    parameter int PACKET_WIDTH   = UC_PACKET_WIDTH,
    parameter int ADDR_WIDTH     = UC_ADDR_WIDTH,
    parameter int BANK_SEL_LO    = UC_INDEX_POS_LO,
    parameter int PORT_NUM_LO    = UC_PORT_NUM_LO,
    parameter int PORT_ID_WIDTH  = $clog2(NUM_INPUT_PORT) + 1,
    parameter int STARVE_LIMIT   = UC_STARVE_LIMIT
) (
    input  logic                                    clk_in,
    input  logic                                    reset_in,
    input  logic [NUM_INPUT_PORT*PACKET_WIDTH-1:0]  request_flatted_in,
    input  logic [NUM_INPUT_PORT-1:0]               request_valid_flatted_in,
    input  logic [NUM_INPUT_PORT-1:0]               request_critical_flatted_in,
    output logic [NUM_INPUT_PORT-1:0]               issue_ack_out,
    output logic [NUM_BANK*PACKET_WIDTH-1:0]        bank_request_flatted_out,
    output logic [NUM_BANK-1:0]                     bank_request_valid_flatted_out,
    input  logic [NUM_BANK-1:0]                     bank_issue_ack_in
);

    localparam int BANK_W = idx_width(NUM_BANK);
    localparam int PTR_W  = idx_width(NUM_INPUT_PORT);
    localparam int AGE_W  = idx_width(STARVE_LIMIT + 1);
    // Bank-select bits must sit inside the address field; fall back to bit 0 otherwise.
    localparam int SEL_LO = (BANK_SEL_LO + BANK_W <= ADDR_WIDTH) ? BANK_SEL_LO : 0;

    logic [PACKET_WIDTH-1:0]   req_pkt     [NUM_INPUT_PORT];
    logic [BANK_W-1:0]         req_bank    [NUM_INPUT_PORT];
    logic [AGE_W-1:0]          age_q       [NUM_INPUT_PORT];
    logic [NUM_INPUT_PORT-1:0] eff_crit;
    logic [NUM_INPUT_PORT-1:0] bank_req    [NUM_BANK];
    logic [NUM_INPUT_PORT-1:0] bank_grant  [NUM_BANK];
    logic [NUM_BANK-1:0]       grant_valid;
    logic [NUM_BANK-1:0]       slot_accept;
    logic [NUM_BANK-1:0]       slot_valid_q;
    logic [PACKET_WIDTH-1:0]   win_pkt     [NUM_BANK];
    logic [PACKET_WIDTH-1:0]   slot_pkt_q  [NUM_BANK];
    logic [PTR_W-1:0]          unused_rr_ptr [NUM_BANK];

    for (genvar p = 0; p < NUM_INPUT_PORT; p++) begin : g_port
        assign req_pkt[p] = request_flatted_in[p*PACKET_WIDTH +: PACKET_WIDTH];
        if (NUM_BANK > 1) begin : g_sel
            assign req_bank[p] = req_pkt[p][SEL_LO +: BANK_W];
        end else begin : g_one
            assign req_bank[p] = '0;
        end
        assign eff_crit[p] = request_critical_flatted_in[p] | (age_q[p] == AGE_W'(STARVE_LIMIT));
    end

    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int p = 0; p < NUM_INPUT_PORT; p++) begin
                bank_req[b][p] = request_valid_flatted_in[p] && (int'(req_bank[p]) == b);
            end
        end
    end

    // Handshake: input side pops on issue_ack_out[p] (valid & grant, same cycle); bank side
    // consumes a slot when bank_request_valid & bank_issue_ack_in are both high on an edge.
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        assign slot_accept[b] = ~slot_valid_q[b] | bank_issue_ack_in[b];

        unified_cache_rr_arbiter #(
            .NUM_REQUEST (NUM_INPUT_PORT)
        ) u_arb (
            .clk         (clk_in),
            .rst_n       (reset_in),
            .enable      (slot_accept[b] & reset_in),
            .request     (bank_req[b]),
            .critical    (eff_crit),
            .grant       (bank_grant[b]),
            .grant_valid (grant_valid[b]),
            .pointer     (unused_rr_ptr[b])
        );

        assign bank_request_flatted_out[b*PACKET_WIDTH +: PACKET_WIDTH] = slot_pkt_q[b];
    end

    assign bank_request_valid_flatted_out = slot_valid_q;

    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            win_pkt[b] = '0;
            for (int p = 0; p < NUM_INPUT_PORT; p++) begin
                if (bank_grant[b][p]) begin
                    win_pkt[b] = req_pkt[p];
                    win_pkt[b][PORT_NUM_LO +: PORT_ID_WIDTH] = PORT_ID_WIDTH'(p);
                end
            end
        end
    end

    // A port addresses one bank, so at most one bank can grant it per cycle.
    always_comb begin
        issue_ack_out = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            issue_ack_out = issue_ack_out | bank_grant[b];
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            slot_valid_q <= '0;
            for (int b = 0; b < NUM_BANK; b++) begin
                slot_pkt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (grant_valid[b]) begin
                    slot_valid_q[b] <= 1'b1;
                    slot_pkt_q[b]   <= win_pkt[b];
                end else if (bank_issue_ack_in[b]) begin
                    slot_valid_q[b] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int p = 0; p < NUM_INPUT_PORT; p++) begin
                age_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_INPUT_PORT; p++) begin
                if (request_valid_flatted_in[p] && !issue_ack_out[p]) begin
                    if (age_q[p] != AGE_W'(STARVE_LIMIT)) begin
                        age_q[p] <= age_q[p] + 1'b1;
                    end
                end else begin
                    age_q[p] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_unified_cache_request_crossbar.sv
// Bench for the cache request crossbar: reset, table-driven routing/contention vectors,
// hand-written starvation/backpressure/mid-op-reset sequences and a randomized run.
module tb_unified_cache_request_crossbar;
    import unified_cache_request_crossbar_pkg::*;

    localparam int NIP    = 2;
    localparam int NB     = 4;
    localparam int PW     = UC_PACKET_WIDTH;
    localparam int ID_LO  = UC_PORT_NUM_LO;
    localparam int SEL_LO = UC_INDEX_POS_LO;
    localparam int LIMIT  = UC_STARVE_LIMIT;

    // ---------------- clock / reset ----------------
    logic clk_in;
    logic reset_in;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT ----------------
    logic [NIP-1:0]    drv_valid;
    logic [NIP-1:0]    drv_crit;
    logic [PW-1:0]     drv_pkt [NIP];
    logic [NB-1:0]     drv_back;
    logic [NIP*PW-1:0] req_flat;
    logic [NIP-1:0]    issue_ack;
    logic [NB*PW-1:0]  bank_flat;
    logic [NB-1:0]     bank_valid;

    always_comb begin
        req_flat = '0;
        for (int p = 0; p < NIP; p++) req_flat[p*PW +: PW] = drv_pkt[p];
    end

    unified_cache_request_crossbar dut (
        .clk_in                         (clk_in),
        .reset_in                       (reset_in),
        .request_flatted_in             (req_flat),
        .request_valid_flatted_in       (drv_valid),
        .request_critical_flatted_in    (drv_crit),
        .issue_ack_out                  (issue_ack),
        .bank_request_flatted_out       (bank_flat),
        .bank_request_valid_flatted_out (bank_valid),
        .bank_issue_ack_in              (drv_back)
    );

    // ---------------- check / packet helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mk_pkt(input int bank, input int tag);
        logic [PW-1:0] pk;
        pk = '0;
        pk[SEL_LO +: 2] = bank[1:0];
        pk[15:8]        = tag[7:0];
        pk[31:24]       = ~tag[7:0];
        pk[39:36]       = tag[3:0];
        pk[ID_LO +: 2]  = 2'b11;
        return pk;
    endfunction

    function automatic logic [PW-1:0] stamp(input logic [PW-1:0] pk, input int id);
        logic [PW-1:0] r;
        r = pk;
        r[ID_LO +: 2] = id[1:0];
        return r;
    endfunction

    function automatic int bank_of(input logic [PW-1:0] pk);
        return int'(pk[SEL_LO +: 2]);
    endfunction

    // ---------------- reference model + scoreboard ----------------
    logic [NB-1:0]  m_valid;
    int             m_ptr [NB];
    int             m_age [NIP];
    int             m_win [NB];
    logic [NIP-1:0] m_ack;
    logic [PW-1:0]  exp_q [NB][$];

    function automatic void reset_model();
        m_valid = '0;
        m_ack   = '0;
        for (int b = 0; b < NB; b++) begin
            m_ptr[b] = 0;
            m_win[b] = -1;
            exp_q[b].delete();
        end
        for (int p = 0; p < NIP; p++) m_age[p] = 0;
    endfunction

    // Winner = requester of the chosen class closest to the pointer, counting forward.
    function automatic void model_eval();
        m_ack = '0;
        for (int b = 0; b < NB; b++) begin
            int all_q[$];
            int crit_q[$];
            int use_q[$];
            int best;
            int best_d;
            m_win[b] = -1;
            if (!m_valid[b] || drv_back[b]) begin
                for (int p = 0; p < NIP; p++) begin
                    if (drv_valid[p] && bank_of(drv_pkt[p]) == b) begin
                        all_q.push_back(p);
                        if (drv_crit[p] || m_age[p] == LIMIT) crit_q.push_back(p);
                    end
                end
                use_q  = (crit_q.size() > 0) ? crit_q : all_q;
                best   = -1;
                best_d = NIP;
                foreach (use_q[k]) begin
                    int d;
                    d = (use_q[k] - m_ptr[b] + NIP) % NIP;
                    if (d < best_d) begin
                        best_d = d;
                        best   = use_q[k];
                    end
                end
                m_win[b] = best;
                if (best >= 0) m_ack[best] = 1'b1;
            end
        end
    endfunction

    function automatic void model_commit();
        for (int b = 0; b < NB; b++) begin
            if (drv_back[b] && m_valid[b] && exp_q[b].size() > 0) void'(exp_q[b].pop_front());
            if (m_win[b] >= 0) begin
                exp_q[b].push_back(stamp(drv_pkt[m_win[b]], m_win[b]));
                m_valid[b] = 1'b1;
                m_ptr[b]   = (m_win[b] + 1) % NIP;
            end else if (drv_back[b]) begin
                m_valid[b] = 1'b0;
            end
        end
        for (int p = 0; p < NIP; p++) begin
            if (drv_valid[p] && !m_ack[p]) m_age[p] = (m_age[p] < LIMIT) ? m_age[p] + 1 : LIMIT;
            else m_age[p] = 0;
        end
    endfunction

    // ---------------- driver tasks ----------------
    logic [NIP-1:0] seen_ack;
    logic [NB-1:0]  seen_vout;
    logic [PW-1:0]  seen_slot [NB];

    task automatic set_port(input int p, input logic v, input logic c, input int bank, input int tag);
        drv_valid[p] = v;
        drv_crit[p]  = c;
        drv_pkt[p]   = mk_pkt(bank, tag);
    endtask

    // One clock: sample and check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk_in);
        model_eval();
        seen_ack  = issue_ack;
        seen_vout = bank_valid;
        for (int b = 0; b < NB; b++) seen_slot[b] = bank_flat[b*PW +: PW];
        check("ack", seen_ack, m_ack);
        check("valid_out", seen_vout, m_valid);
        for (int b = 0; b < NB; b++) begin
            if (m_valid[b]) begin
                if (exp_q[b].size() != 1) check("sb_depth", exp_q[b].size(), 1);
                else check("slot_data", seen_slot[b], exp_q[b][0]);
            end
        end
        @(posedge clk_in);
        model_commit();
        #1;
    endtask

    task automatic apply_reset();
        reset_in = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        reset_model();
        reset_in = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] valid;
        logic [1:0] crit;
        logic [1:0] bank0;
        logic [1:0] bank1;
        logic [3:0] back;
        logic [1:0] exp_ack;
        logic [3:0] exp_vout;
        logic [7:0] exp_ids;
    } vec_t;

    vec_t vecs [12];

    logic [PW-1:0] in_q [NIP][$];

    initial begin
        int cnt0;
        int cnt1;
        int tag_ctr;
        logic [PW-1:0] held;

        vecs[0]  = '{2'b11, 2'b00, 2'd2, 2'd1, 4'b0000, 2'b11, 4'b0000, 8'b00_00_00_00};
        vecs[1]  = '{2'b00, 2'b00, 2'd2, 2'd1, 4'b0000, 2'b00, 4'b0110, 8'b00_00_01_00};
        vecs[2]  = '{2'b11, 2'b00, 2'd2, 2'd1, 4'b0000, 2'b00, 4'b0110, 8'b00_00_01_00};
        vecs[3]  = '{2'b11, 2'b00, 2'd2, 2'd1, 4'b0100, 2'b01, 4'b0110, 8'b00_00_01_00};
        vecs[4]  = '{2'b00, 2'b00, 2'd2, 2'd1, 4'b0110, 2'b00, 4'b0110, 8'b00_00_01_00};
        vecs[5]  = '{2'b00, 2'b00, 2'd2, 2'd1, 4'b1111, 2'b00, 4'b0000, 8'b00_00_00_00};
        vecs[6]  = '{2'b11, 2'b00, 2'd3, 2'd3, 4'b0000, 2'b01, 4'b0000, 8'b00_00_00_00};
        vecs[7]  = '{2'b11, 2'b00, 2'd3, 2'd3, 4'b1000, 2'b10, 4'b1000, 8'b00_00_00_00};
        vecs[8]  = '{2'b11, 2'b00, 2'd3, 2'd3, 4'b1000, 2'b01, 4'b1000, 8'b01_00_00_00};
        vecs[9]  = '{2'b11, 2'b10, 2'd0, 2'd0, 4'b0000, 2'b10, 4'b1000, 8'b00_00_00_00};
        vecs[10] = '{2'b00, 2'b00, 2'd0, 2'd0, 4'b1001, 2'b00, 4'b1001, 8'b00_00_00_01};
        vecs[11] = '{2'b00, 2'b00, 2'd0, 2'd0, 4'b0000, 2'b00, 4'b0000, 8'b00_00_00_00};

        // Reset with requests pending: nothing acked, nothing valid, packets zero.
        reset_in = 1'b0;
        drv_back = 4'b0000;
        set_port(0, 1'b1, 1'b0, 2, 0);
        set_port(1, 1'b1, 1'b0, 1, 1);
        reset_model();
        @(negedge clk_in);
        @(negedge clk_in);
        check("reset_ack", issue_ack, 2'b00);
        check("reset_valid", bank_valid, 4'b0000);
        for (int b = 0; b < NB; b++) check("reset_pkt", bank_flat[b*PW +: PW], '0);
        @(posedge clk_in);
        #1;
        reset_in = 1'b1;

        // Table: routing, backpressure hold, contention RR, critical win.
        for (int i = 0; i < 12; i++) begin
            drv_back = vecs[i].back;
            set_port(0, vecs[i].valid[0], vecs[i].crit[0], int'(vecs[i].bank0), i*4);
            set_port(1, vecs[i].valid[1], vecs[i].crit[1], int'(vecs[i].bank1), i*4 + 1);
            tick();
            check("tbl_ack", seen_ack, vecs[i].exp_ack);
            check("tbl_vout", seen_vout, vecs[i].exp_vout);
            for (int b = 0; b < NB; b++) begin
                if (vecs[i].exp_vout[b]) check("tbl_port_id", seen_slot[b][ID_LO +: 2], vecs[i].exp_ids[2*b +: 2]);
            end
        end

        // Contention on bank 3 from a fresh pointer: strict alternation, 10/10.
        apply_reset();
        drv_back = 4'b1111;
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 20; i++) begin
            set_port(0, 1'b1, 1'b0, 3, 8'h40 + i);
            set_port(1, 1'b1, 1'b0, 3, 8'h60 + i);
            tick();
            check("contention_ack", seen_ack, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (seen_ack[0]) cnt0++;
            if (seen_ack[1]) cnt1++;
        end
        check("port0_share", cnt0, 10);
        check("port1_share", cnt1, 10);

        // Critical port1 vs normal port0 on bank 0: port0 promoted once its age reaches the limit.
        drv_valid = 2'b00;
        tick();
        for (int i = 0; i <= LIMIT + 1; i++) begin
            set_port(0, 1'b1, 1'b0, 0, 8'h80 + i);
            set_port(1, 1'b1, 1'b1, 0, 8'h90 + i);
            tick();
            check("critical_ack", seen_ack, (i == LIMIT) ? 2'b01 : 2'b10);
        end

        // Backpressure on bank 0: slot holds, no acks; then drain and refill with no bubble.
        drv_valid = 2'b00;
        drv_crit  = 2'b00;
        tick();
        set_port(0, 1'b1, 1'b0, 0, 8'hA0);
        set_port(1, 1'b1, 1'b0, 0, 8'hB0);
        tick();
        check("bp_first_ack", seen_ack, 2'b01);
        held = stamp(mk_pkt(0, 8'hA0), 0);
        set_port(0, 1'b1, 1'b0, 0, 8'hA1);
        drv_back = 4'b1110;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_ack", seen_ack, 2'b00);
            check("bp_valid", seen_vout[0], 1'b1);
            check("bp_hold", seen_slot[0], held);
        end
        drv_back = 4'b1111;
        tick();
        check("bp_drain_ack", seen_ack, 2'b10);
        check("bp_drain_valid", seen_vout[0], 1'b1);
        drv_valid = 2'b00;
        tick();
        check("bp_refill_valid", seen_vout[0], 1'b1);
        check("bp_refill_data", seen_slot[0], stamp(mk_pkt(0, 8'hB0), 1));

        // Mid-operation reset with three slots full.
        drv_back = 4'b0000;
        set_port(0, 1'b1, 1'b0, 1, 8'hC0);
        set_port(1, 1'b1, 1'b0, 2, 8'hC1);
        tick();
        set_port(0, 1'b1, 1'b0, 3, 8'hC2);
        set_port(1, 1'b0, 1'b0, 2, 8'hC1);
        tick();
        set_port(1, 1'b1, 1'b0, 0, 8'hC3);
        #1;
        check("pre_reset_valid", bank_valid, 4'b1110);
        reset_in = 1'b0;
        #1;
        check("async_reset_valid", bank_valid, 4'b0000);
        check("async_reset_ack", issue_ack, 2'b00);
        for (int b = 0; b < NB; b++) check("async_reset_pkt", bank_flat[b*PW +: PW], '0);
        reset_model();
        @(posedge clk_in);
        #1;
        reset_in = 1'b1;
        drv_back = 4'b1111;
        set_port(0, 1'b1, 1'b0, 3, 8'hD0);
        set_port(1, 1'b1, 1'b0, 3, 8'hD1);
        tick();
        check("rr_after_reset", seen_ack, 2'b01);

        // Randomized traffic against the model; second half is backpressure-heavy on few banks.
        apply_reset();
        tag_ctr = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < NIP; p++) begin
                if (in_q[p].size() < 4 && $urandom_range(0, 2) == 0) begin
                    in_q[p].push_back(mk_pkt((cyc < 300) ? $urandom_range(0, 3) : $urandom_range(0, 1), tag_ctr));
                    tag_ctr++;
                end
                drv_valid[p] = (in_q[p].size() > 0) && ($urandom_range(0, 4) != 0);
                drv_pkt[p]   = (in_q[p].size() > 0) ? in_q[p][0] : '0;
                drv_crit[p]  = ($urandom_range(0, 9) == 0);
            end
            for (int b = 0; b < NB; b++) begin
                drv_back[b] = (cyc < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            end
            tick();
            for (int p = 0; p < NIP; p++) begin
                if (m_ack[p] && in_q[p].size() > 0) void'(in_q[p].pop_front());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
